// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline stage register: occupancy encoding and a helper
// that turns the per-entry valid bits into that encoding.
package pipe_pkg;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

    function automatic logic [1:0] occ_of(input logic a_valid, input logic b_valid);
        case ({a_valid, b_valid})
            2'b11:   return OCC_FULL;
            2'b00:   return OCC_EMPTY;
            default: return OCC_ONE;
        endcase
    endfunction

endpackage

// File: rtl/pipe_entry.sv
// One storage entry of the pipeline stage: WIDTH-bit payload plus valid bit.
// Synchronous clear wins over load; with neither asserted the entry holds.
module pipe_entry
    import pipe_pkg::*;
#(
    parameter int              WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic             Clk,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    always_ff @(posedge Clk) begin
        if (i_clr) begin
            r_valid <= 1'b0;
            r_data  <= RESET_DATA;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with hazard stall and control flush.
// Define PIPE_STAGE_SKID_EN for the 2-entry skid version (registered in_ready).
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic             Clk,
    input  logic             Clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             stall,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // Once out_valid is high, out_valid/out_data hold until out_ready is seen.
    logic             w_out_valid;
    logic [WIDTH-1:0] w_out_data;
    logic             w_out_free;
    logic             w_accept;
    logic             w_out_clr;
    logic             w_out_load;
    logic [WIDTH-1:0] w_out_din;

    assign w_out_free = !w_out_valid || out_ready;
    assign w_accept   = in_valid && in_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic             w_skid_valid;
    logic [WIDTH-1:0] w_skid_data;
    logic             w_skid_clr;
    logic             w_skid_load;

    // Ready depends only on the skid register, never on out_ready.
    assign in_ready = !w_skid_valid && !stall && !Clr;

    // A draining output reg refills from the skid entry first to keep order;
    // under stall it takes a bubble and the skid entry waits.
    assign w_out_din  = w_skid_valid ? w_skid_data : in_data;
    assign w_out_load = !flush && w_out_free && !stall && (w_skid_valid || w_accept);
    assign w_out_clr  = Clr || flush ||
                        (w_out_free && (stall || (!w_skid_valid && !w_accept)));

    assign w_skid_load = w_accept && !flush && !w_out_free;
    assign w_skid_clr  = Clr || flush || (w_out_free && !stall && w_skid_valid);

    pipe_entry #(
        .WIDTH      (WIDTH),
        .RESET_DATA (RESET_DATA)
    ) u_skid_entry (
        .Clk     (Clk),
        .i_clr   (w_skid_clr),
        .i_load  (w_skid_load),
        .i_data  (in_data),
        .o_valid (w_skid_valid),
        .o_data  (w_skid_data)
    );

    assign occupancy = occ_of(w_out_valid, w_skid_valid);
`else
    assign in_ready = !stall && w_out_free && !Clr;

    // No accept while the register frees up (idle or stalled) leaves a bubble.
    assign w_out_din  = in_data;
    assign w_out_load = w_accept && !flush;
    assign w_out_clr  = Clr || flush || (w_out_free && !w_accept);

    assign occupancy = occ_of(w_out_valid, 1'b0);
`endif

    pipe_entry #(
        .WIDTH      (WIDTH),
        .RESET_DATA (RESET_DATA)
    ) u_out_entry (
        .Clk     (Clk),
        .i_clr   (w_out_clr),
        .i_load  (w_out_load),
        .i_data  (w_out_din),
        .o_valid (w_out_valid),
        .o_data  (w_out_data)
    );

    assign out_valid = w_out_valid;
    assign out_data  = w_out_data;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a 64-bit and a 1-bit instance share all control inputs.
// Directed table vectors plus random traffic, checked by per-instance scoreboards.
module tb_pipe_stage_reg;

    localparam logic [63:0] RW = 64'hC0DE_0000_0000_0001;
    localparam logic [0:0]  RN = 1'b1;

    typedef struct {
        logic        clr, stall, flush, in_valid, out_ready;
        logic [63:0] in_data;
        logic        tbl;
        logic        exp_rdy, exp_ov, chk_od;
        logic [63:0] exp_od;
        logic [1:0]  exp_occ;
    } vec_t;

    logic        Clk = 1'b0;
    logic        Clr, in_valid, stall, flush, out_ready;
    logic [63:0] in_data;
    logic [0:0]  in_data_n;

    logic        in_ready_w, out_valid_w;
    logic [63:0] out_data_w;
    logic [1:0]  occ_w;
    logic        in_ready_n, out_valid_n;
    logic [0:0]  out_data_n;
    logic [1:0]  occ_n;

    logic [63:0] exp_q[$];
    logic [0:0]  exp_q1[$];
    vec_t        vecs[$];
    int          n_chk  = 0;
    int          n_pass = 0;

    assign in_data_n = in_data[0];

    always #5 Clk = ~Clk;

    pipe_stage_reg #(.WIDTH(64), .RESET_DATA(RW)) u_dut_w (
        .Clk(Clk), .Clr(Clr), .in_valid(in_valid), .in_ready(in_ready_w),
        .in_data(in_data), .stall(stall), .flush(flush), .out_valid(out_valid_w),
        .out_ready(out_ready), .out_data(out_data_w), .occupancy(occ_w)
    );

    pipe_stage_reg #(.WIDTH(1), .RESET_DATA(RN)) u_dut_n (
        .Clk(Clk), .Clr(Clr), .in_valid(in_valid), .in_ready(in_ready_n),
        .in_data(in_data_n), .stall(stall), .flush(flush), .out_valid(out_valid_n),
        .out_ready(out_ready), .out_data(out_data_n), .occupancy(occ_n)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic vec_t mk(input int c, input int s, input int f, input int iv,
                                input int ord, input logic [63:0] d, input int rdy,
                                input int ov, input logic [63:0] od, input int occ,
                                input int cod);
        vec_t v;
        v.clr = (c != 0);      v.stall = (s != 0);     v.flush = (f != 0);
        v.in_valid = (iv != 0); v.out_ready = (ord != 0); v.in_data = d;
        v.tbl = 1'b1;          v.exp_rdy = (rdy != 0); v.exp_ov = (ov != 0);
        v.exp_od = od;         v.exp_occ = occ[1:0];   v.chk_od = (cod != 0);
        return v;
    endfunction

    task automatic step(input vec_t v, input string nm);
        logic acc_w, acc_n, del_w, del_n;
        @(negedge Clk);
        Clr = v.clr; stall = v.stall; flush = v.flush;
        in_valid = v.in_valid; out_ready = v.out_ready; in_data = v.in_data;
        #1;
        if (v.tbl) begin
            chk({nm, ".w_in_ready"}, 64'(in_ready_w), 64'(v.exp_rdy));
            chk({nm, ".n_in_ready"}, 64'(in_ready_n), 64'(v.exp_rdy));
        end
        acc_w = in_valid && in_ready_w && !flush && !Clr;
        acc_n = in_valid && in_ready_n && !flush && !Clr;
        del_w = out_valid_w && out_ready;
        del_n = out_valid_n && out_ready;
        if (del_w) begin
            chk({nm, ".w_sb_nonempty"}, 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) chk({nm, ".w_sb_data"}, out_data_w, exp_q.pop_front());
        end
        if (del_n) begin
            chk({nm, ".n_sb_nonempty"}, 64'(exp_q1.size() > 0), 64'd1);
            if (exp_q1.size() > 0) chk({nm, ".n_sb_data"}, 64'(out_data_n), 64'(exp_q1.pop_front()));
        end
        if (v.clr || v.flush) begin
            exp_q.delete();
            exp_q1.delete();
        end else begin
            if (acc_w) exp_q.push_back(v.in_data);
            if (acc_n) exp_q1.push_back(v.in_data[0]);
        end
        @(posedge Clk);
        #1;
        if (v.tbl) begin
            chk({nm, ".w_out_valid"}, 64'(out_valid_w), 64'(v.exp_ov));
            chk({nm, ".n_out_valid"}, 64'(out_valid_n), 64'(v.exp_ov));
            chk({nm, ".w_occ"}, 64'(occ_w), 64'(v.exp_occ));
            if (v.chk_od) begin
                chk({nm, ".w_out_data"}, out_data_w, v.exp_od);
                chk({nm, ".n_out_data"}, 64'(out_data_n), 64'(v.exp_od[0]));
            end
        end
        chk({nm, ".w_occ_vs_sb"}, 64'(occ_w), 64'(exp_q.size()));
        chk({nm, ".n_occ_vs_sb"}, 64'(occ_n), 64'(exp_q1.size()));
    endtask

    initial begin
        vec_t r;
        Clr = 1'b1; stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
        out_ready = 1'b0; in_data = 64'h0;

        // reset, then first-cycle-after-reset readiness
        vecs.push_back(mk(1,0,0,1,0,64'h77, 0,0,RW,0,1));
        vecs.push_back(mk(1,0,0,0,0,64'h0,  0,0,RW,0,1));
        // streaming 1..4
        vecs.push_back(mk(0,0,0,1,1,64'h1, 1,1,64'h1,1,1));
        vecs.push_back(mk(0,0,0,1,1,64'h2, 1,1,64'h2,1,1));
        vecs.push_back(mk(0,0,0,1,1,64'h3, 1,1,64'h3,1,1));
        vecs.push_back(mk(0,0,0,1,1,64'h4, 1,1,64'h4,1,1));
        vecs.push_back(mk(0,0,0,0,1,64'h0, 1,0,64'h0,0,0));
        // stall: bubble, later accept; stall while held; stall while draining
        vecs.push_back(mk(0,1,0,1,1,64'h5, 0,0,RW,0,1));
        vecs.push_back(mk(0,0,0,1,1,64'h5, 1,1,64'h5,1,1));
        vecs.push_back(mk(0,0,0,0,1,64'h0, 1,0,64'h0,0,0));
        vecs.push_back(mk(0,0,0,1,0,64'h6, 1,1,64'h6,1,1));
        vecs.push_back(mk(0,1,0,1,0,64'h7, 0,1,64'h6,1,1));
        vecs.push_back(mk(0,1,0,0,1,64'h0, 0,0,RW,0,1));
`ifdef PIPE_STAGE_SKID_EN
        // backpressure into the skid entry
        vecs.push_back(mk(0,0,0,1,1,64'hA, 1,1,64'hA,1,1));
        vecs.push_back(mk(0,0,0,1,0,64'hB, 1,1,64'hA,2,1));
        vecs.push_back(mk(0,0,0,0,0,64'h0, 0,1,64'hA,2,1));
        vecs.push_back(mk(0,0,0,0,1,64'h0, 0,1,64'hB,1,1));
        vecs.push_back(mk(0,0,0,0,1,64'h0, 1,0,64'h0,0,0));
        // flush at occupancy 2 drops the offered input
        vecs.push_back(mk(0,0,0,1,1,64'hC, 1,1,64'hC,1,1));
        vecs.push_back(mk(0,0,0,1,0,64'hD, 1,1,64'hC,2,1));
        vecs.push_back(mk(0,0,1,1,0,64'hE, 0,0,RW,0,1));
        vecs.push_back(mk(0,0,0,1,1,64'hE, 1,1,64'hE,1,1));
        vecs.push_back(mk(0,0,0,0,1,64'h0, 1,0,64'h0,0,0));
`else
        vecs.push_back(mk(0,0,0,1,1,64'hA, 1,1,64'hA,1,1));
        vecs.push_back(mk(0,0,0,1,0,64'hB, 0,1,64'hA,1,1));
        vecs.push_back(mk(0,0,0,1,0,64'hB, 0,1,64'hA,1,1));
        vecs.push_back(mk(0,0,0,1,1,64'hB, 1,1,64'hB,1,1));
        vecs.push_back(mk(0,0,0,0,1,64'h0, 1,0,64'h0,0,0));
        vecs.push_back(mk(0,0,0,1,1,64'hC, 1,1,64'hC,1,1));
        vecs.push_back(mk(0,0,1,1,0,64'hD, 0,0,RW,0,1));
`endif
        // flush with ready high drops input; flush beats stall
        vecs.push_back(mk(0,0,1,1,1,64'hEE, 1,0,RW,0,1));
        vecs.push_back(mk(0,1,1,1,1,64'hFF, 0,0,RW,0,1));
        // reset mid-stream dominates stall and flush
        vecs.push_back(mk(0,0,0,1,1,64'h11, 1,1,64'h11,1,1));
        vecs.push_back(mk(1,1,1,1,0,64'h12, 0,0,RW,0,1));
        vecs.push_back(mk(0,0,0,1,1,64'h13, 1,1,64'h13,1,1));
        vecs.push_back(mk(0,0,0,1,1,64'hFEDC_BA98_7654_3210, 1,1,64'hFEDC_BA98_7654_3210,1,1));
        vecs.push_back(mk(0,0,0,0,1,64'h0, 1,0,64'h0,0,0));

        for (int i = 0; i < vecs.size(); i++) step(vecs[i], $sformatf("v%0d", i));

        for (int i = 0; i < 400; i++) begin
            r = mk(0,0,0,0,0,64'h0, 0,0,64'h0,0,0);
            r.tbl       = 1'b0;
            r.in_valid  = ($urandom_range(0, 3) != 0);
            r.out_ready = ($urandom_range(0, 3) != 0);
            r.stall     = ($urandom_range(0, 9) == 0);
            r.flush     = ($urandom_range(0, 49) == 0);
            r.in_data   = {$urandom, $urandom};
            step(r, $sformatf("rnd%0d", i));
        end

        for (int i = 0; i < 8 && (exp_q.size() > 0 || exp_q1.size() > 0); i++) begin
            r = mk(0,0,0,0,1,64'h0, 0,0,64'h0,0,0);
            r.tbl = 1'b0;
            step(r, $sformatf("drain%0d", i));
        end
        chk("drain.w_sb_empty", 64'(exp_q.size()), 64'd0);
        chk("drain.n_sb_empty", 64'(exp_q1.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the payload width in bits, legal range 1..1024.
REQ-002 SHALL have parameter RESET_DATA, default 0, WIDTH bits, the value of out_data after reset or flush.
REQ-003 SHALL have port Clk, input, 1 bit, the single clock, rising edge.
REQ-004 SHALL have port Clr, input, 1 bit, the reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit, upstream holds a payload.
REQ-006 SHALL have port in_ready, output, 1 bit, the stage accepts a payload this cycle.
REQ-007 SHALL have port in_data, input, WIDTH bits, the upstream payload.
REQ-008 SHALL have port stall, input, 1 bit, the hazard stall: blocks acceptance and inserts a bubble downstream.
REQ-009 SHALL have port flush, input, 1 bit, the branch/control flush: kills all held payloads.
REQ-010 SHALL have port out_valid, output, 1 bit, the stage presents a payload.
REQ-011 SHALL have port out_ready, input, 1 bit, downstream accepts.
REQ-012 SHALL have port out_data, output, WIDTH bits, the presented payload.
REQ-013 SHALL have port occupancy, output, 2 bits, the count of held payloads (0..2).

Function
REQ-014 SHALL complete an input transfer on a rising edge where in_valid && in_ready, and an output transfer where out_valid && out_ready.
REQ-015 SHALL drive in_ready = 0 whenever stall = 1; in_valid is ignored and no payload is captured that cycle.
REQ-016 SHALL, when stall = 1 and the output register is empty or being drained, load a bubble (out_valid = 0, out_data = RESET_DATA).
REQ-017 SHALL, when flush = 1, clear all entries at the next edge (occupancy 0, out_valid 0, out_data RESET_DATA), and SHALL drop any input transfer in that cycle.
REQ-018 SHALL give flush priority over stall, and stall priority over in_valid.
REQ-019 SHALL present an accepted payload on out_data exactly 1 cycle after acceptance when the stage is empty.
REQ-020 SHALL hold out_data and out_valid stable while out_valid && !out_ready.
REQ-021 SHALL preserve order and lose or duplicate no payload.
REQ-022 SHALL update occupancy each edge: +1 on input only, -1 on output only, unchanged on both or neither; 0 after flush.
REQ-023 SHALL sustain one transfer per cycle with in_valid = out_ready = 1 and stall = flush = 0.

Reset
REQ-024 SHALL, on a Clk edge with Clr = 1, set out_valid = 0, out_data = RESET_DATA, occupancy = 0 and the skid entry to empty, overriding flush, stall and all transfers.
REQ-025 SHALL drive in_ready = 0 during Clr = 1, and SHALL drive in_ready = 1 in the first cycle after Clr deasserts (unless stall = 1).

Configuration
REQ-026 SHALL, with PIPE_STAGE_SKID_EN defined, include a 2-entry skid buffer: in_ready is registered (= skid entry empty), not combinational from out_ready; occupancy reaches 2 when out_ready falls while a transfer is in flight.
REQ-027 SHALL, without PIPE_STAGE_SKID_EN, use a single entry: in_ready = !stall && (!out_valid || out_ready) && !Clr (combinational); occupancy never exceeds 1.

Structure
REQ-028 SHALL take the occupancy encoding constants (OCC_EMPTY = 0, OCC_ONE = 1, OCC_FULL = 2) from shared package pipe_pkg.
REQ-029 SHALL implement each storage entry as sub-module pipe_entry (WIDTH-bit data plus valid, synchronous clear, load enable); the block instantiates one or two of these.

Verification
REQ-030 SHALL cover streaming: in_valid = out_ready = 1 with in_data 1,2,3,4 -> out_data 1,2,3,4 on the next 4 cycles, occupancy 1 throughout.
REQ-031 SHALL cover backpressure (skid on): after accepting 0xA, drop out_ready with in_valid = 1 and in_data = 0xB -> occupancy 2, in_ready = 0, out_data 0xA held; raise out_ready -> 0xA then 0xB delivered in order.
REQ-032 SHALL cover stall: stall = 1 for 1 cycle with in_valid = 1 and in_data = 0x5 -> in_ready = 0 and out_valid = 0 next cycle; 0x5 accepted the cycle after stall drops.
REQ-033 SHALL cover flush: occupancy 2 with flush = 1 and in_valid = 1 -> next cycle occupancy 0, out_valid 0, out_data = RESET_DATA, input dropped.
REQ-034 SHALL cover reset: Clr = 1 mid-stream with occupancy 1 -> next edge all outputs at reset values; Clr dominates a simultaneous stall/flush.
REQ-035 SHALL cover the boundary: WIDTH = 1 and WIDTH = 64 both pass REQ-030..034, in both PIPE_STAGE_SKID_EN builds.
